// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and the retire classifier for the commit trace buffer
package trace_pkg;

  typedef enum logic [2:0] {
    KIND_ALU   = 3'd0,
    KIND_LOAD  = 3'd1,
    KIND_STORE = 3'd2,
    KIND_NOP   = 3'd3,
    KIND_HALT  = 3'd4
  } rec_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT_PEND,
    ST_DONE,
    ST_TIMEOUT
  } state_t;

  typedef struct packed {
    rec_kind_t   kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rreg;
    logic [15:0] a;
    logic [15:0] b;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  // A load also writes a register, so it must be tested before the plain ALU case.
  function automatic trace_rec_t classify(
    input logic        reg_write,
    input logic        mem_read,
    input logic        mem_write,
    input logic        halt,
    input logic [3:0]  write_reg,
    input logic [15:0] write_data,
    input logic [15:0] mem_addr,
    input logic [15:0] mem_data,
    input logic [15:0] pc,
    input logic [31:0] inum
  );
    trace_rec_t r;
    r      = '0;
    r.inum = inum;
    r.pc   = pc;
    if (reg_write && mem_read) begin
      r.kind = KIND_LOAD;
      r.rreg = write_reg;
      r.a    = write_data;
      r.b    = mem_addr;
    end else if (reg_write) begin
      r.kind = KIND_ALU;
      r.rreg = write_reg;
      r.a    = write_data;
    end else if (halt) begin
      r.kind = KIND_HALT;
    end else if (mem_write) begin
      r.kind = KIND_STORE;
      r.a    = mem_addr;
      r.b    = mem_data;
    end else begin
      r.kind = KIND_NOP;
    end
    return r;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// rtl/commit_trace_buffer_if.sv - retire bus from the cpu and record stream to the reader
interface commit_trace_buffer_if;
  logic        reg_write;
  logic [3:0]  write_reg;
  logic [15:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        halt;
  logic [15:0] pc;

  logic        rec_valid;
  logic        rec_ready;
  logic [2:0]  rec_kind;
  logic [31:0] rec_inum;
  logic [15:0] rec_pc;
  logic [3:0]  rec_reg;
  logic [15:0] rec_a;
  logic [15:0] rec_b;

  modport master (
    output reg_write, write_reg, write_data, mem_read, mem_write, mem_addr, mem_data, halt, pc,
    output rec_ready,
    input  rec_valid, rec_kind, rec_inum, rec_pc, rec_reg, rec_a, rec_b
  );

  modport slave (
    input  reg_write, write_reg, write_data, mem_read, mem_write, mem_addr, mem_data, halt, pc,
    input  rec_ready,
    output rec_valid, rec_kind, rec_inum, rec_pc, rec_reg, rec_a, rec_b
  );
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through circular FIFO with push/pop/full/empty
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 87
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - classifies retired cycles into numbered trace records and queues them
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  commit_trace_buffer_if.slave bus,
  output logic [31:0]          inst_count,
  output logic [31:0]          cycle_count,
  output logic                 overflow,
  output logic                 done,
  output logic                 timeout
);

  localparam logic [31:0] LIMIT = 32'(CYCLE_LIMIT);

  state_t     state_q, state_d;
  trace_rec_t cur_rec;
  trace_rec_t pend_q;
  trace_rec_t head_rec;
  trace_rec_t shown;
  logic [REC_W-1:0] fifo_dout;
  logic [31:0] cycle_next;
  logic fifo_full, fifo_empty, pop, space;
  logic push, push_pend, retire, tick, drop, latch_pend;

  assign cur_rec = classify(bus.reg_write, bus.mem_read, bus.mem_write, bus.halt,
                            bus.write_reg, bus.write_data, bus.mem_addr, bus.mem_data,
                            bus.pc, inst_count);
  assign cycle_next = cycle_count + 32'd1;
  assign pop        = !fifo_empty && bus.rec_ready;
  assign space      = !fifo_full || pop;

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_pend ? pend_q : cur_rec),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_pend  = 1'b0;
    retire     = 1'b0;
    tick       = 1'b0;
    drop       = 1'b0;
    latch_pend = 1'b0;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          retire = 1'b1;
          tick   = 1'b1;
          if (cur_rec.kind == KIND_HALT) begin
            // HALT is never dropped: park it until the reader frees a slot.
            if (space) begin
              push    = 1'b1;
              state_d = ST_DONE;
            end else begin
              latch_pend = 1'b1;
              state_d    = ST_HALT_PEND;
            end
          end else begin
            if (space) push = 1'b1;
            else       drop = 1'b1;
            if (cycle_next == LIMIT) state_d = ST_TIMEOUT;
          end
        end
      end
      ST_HALT_PEND: begin
        tick = 1'b1;
        if (space) begin
          push      = 1'b1;
          push_pend = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_count  <= '0;
      cycle_count <= '0;
      overflow    <= 1'b0;
      pend_q      <= '0;
    end else begin
      if (retire)     inst_count  <= inst_count + 32'd1;
      if (tick)       cycle_count <= cycle_next;
      if (drop)       overflow    <= 1'b1;
      if (latch_pend) pend_q      <= cur_rec;
    end
  end

  assign done    = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
  assign timeout = (state_q == ST_TIMEOUT);

  // Fields read as zero whenever no record is being offered.
  assign head_rec      = trace_rec_t'(fifo_dout);
  assign shown         = fifo_empty ? '0 : head_rec;
  assign bus.rec_valid = !fifo_empty;
  assign bus.rec_kind  = shown.kind;
  assign bus.rec_inum  = shown.inum;
  assign bus.rec_pc    = shown.pc;
  assign bus.rec_reg   = shown.rreg;
  assign bus.rec_a     = shown.a;
  assign bus.rec_b     = shown.b;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - randomized and directed checks of commit_trace_buffer against a queue model
module tb_commit_trace_buffer;

  localparam int DEPTH_A = 4;
  localparam int LIMIT_A = 100000;
  localparam int DEPTH_T = 16;
  localparam int LIMIT_T = 8;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] a;
    logic [15:0] b;
  } mrec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en_t = 1'b0;
  logic [31:0] inst_count, cycle_count, inst_count_t, cycle_count_t;
  logic overflow, done, timeout, overflow_t, done_t, timeout_t;

  commit_trace_buffer_if ifc ();
  commit_trace_buffer_if tif ();

  commit_trace_buffer #(.DEPTH(DEPTH_A), .CYCLE_LIMIT(LIMIT_A)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(ifc),
    .inst_count(inst_count), .cycle_count(cycle_count),
    .overflow(overflow), .done(done), .timeout(timeout)
  );

  commit_trace_buffer #(.DEPTH(DEPTH_T), .CYCLE_LIMIT(LIMIT_T)) dut_t (
    .clk(clk), .rst_n(rst_n), .en(en_t), .bus(tif),
    .inst_count(inst_count_t), .cycle_count(cycle_count_t),
    .overflow(overflow_t), .done(done_t), .timeout(timeout_t)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: a queue of records plus a run mode (0 idle, 1 run, 2 halt pending, 3 done, 4 timeout).
  mrec_t       mq[$];
  mrec_t       m_pend;
  int          m_mode = 0;
  logic [31:0] m_ic = 0;
  logic [31:0] m_cc = 0;
  logic        m_ovf = 1'b0;

  function automatic mrec_t m_classify();
    mrec_t r;
    r = '0;
    r.inum = m_ic;
    r.pc = ifc.pc;
    if (ifc.reg_write && ifc.mem_read) begin
      r.kind = 3'd1; r.rg = ifc.write_reg; r.a = ifc.write_data; r.b = ifc.mem_addr;
    end else if (ifc.reg_write) begin
      r.kind = 3'd0; r.rg = ifc.write_reg; r.a = ifc.write_data;
    end else if (ifc.halt) begin
      r.kind = 3'd4;
    end else if (ifc.mem_write) begin
      r.kind = 3'd2; r.a = ifc.mem_addr; r.b = ifc.mem_data;
    end else begin
      r.kind = 3'd3;
    end
    return r;
  endfunction

  function automatic mrec_t dut_rec();
    return {ifc.rec_kind, ifc.rec_inum, ifc.rec_pc, ifc.rec_reg, ifc.rec_a, ifc.rec_b};
  endfunction

  function automatic mrec_t exp_rec();
    mrec_t r;
    r = '0;
    if (mq.size() > 0) r = mq[0];
    return r;
  endfunction

  // Advance the model by the rules for the inputs now applied, then clock to the next negedge.
  task automatic tick();
    mrec_t r;
    if (!rst_n) begin
      mq.delete(); m_mode = 0; m_ic = 0; m_cc = 0; m_ovf = 1'b0;
    end else begin
      if (mq.size() > 0 && ifc.rec_ready) void'(mq.pop_front());
      case (m_mode)
        0: if (en) m_mode = 1;
        1: begin
          if (!en) m_mode = 0;
          else begin
            r = m_classify();
            m_ic = m_ic + 1;
            m_cc = m_cc + 1;
            if (r.kind == 3'd4) begin
              if (mq.size() < DEPTH_A) begin mq.push_back(r); m_mode = 3; end
              else begin m_pend = r; m_mode = 2; end
            end else begin
              if (mq.size() < DEPTH_A) mq.push_back(r);
              else m_ovf = 1'b1;
              if (m_cc == 32'(LIMIT_A)) m_mode = 4;
            end
          end
        end
        2: begin
          m_cc = m_cc + 1;
          if (mq.size() < DEPTH_A) begin mq.push_back(m_pend); m_mode = 3; end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // k: 0 ALU, 1 LOAD, 2 STORE, 3 NOP, 4 HALT; x/y are the two payload values.
  task automatic set_retire(input int k, input logic [15:0] p, input logic [3:0] r,
                            input logic [15:0] x, input logic [15:0] y);
    ifc.pc = p;
    ifc.reg_write = (k == 0 || k == 1);
    ifc.mem_read = (k == 1);
    ifc.mem_write = (k == 2);
    ifc.halt = (k == 4);
    ifc.write_reg = r;
    ifc.write_data = x;
    ifc.mem_addr = (k == 2) ? x : y;
    ifc.mem_data = y;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; en_t = 1'b0; ifc.rec_ready = 1'b0; tif.rec_ready = 1'b0;
    set_retire(3, 16'h0, 4'h0, 16'h0, 16'h0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    set_retire(0, 16'h0100, 4'h2, 16'h7777, 16'h0);
    tick(); tick();
    checks++; if (ifc.rec_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifc.rec_valid); else passes++;
    checks++; if (dut_rec() !== '0) $display("FAIL reset_fields: got %h want 0", dut_rec()); else passes++;
    checks++; if ({inst_count, cycle_count} !== 64'd0) $display("FAIL reset_counters: got %0d/%0d want 0/0", inst_count, cycle_count); else passes++;
    checks++; if ({overflow, done, timeout} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {overflow, done, timeout}); else passes++;
    en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    mrec_t e[3];
    e[0] = {3'd0, 32'd0, 16'h0000, 4'd3, 16'h1234, 16'h0000};
    e[1] = {3'd3, 32'd1, 16'h0002, 4'd0, 16'h0000, 16'h0000};
    e[2] = {3'd4, 32'd2, 16'h0004, 4'd0, 16'h0000, 16'h0000};
    do_reset();
    en = 1'b1; tick();
    set_retire(0, 16'h0000, 4'd3, 16'h1234, 16'h5A5A); tick();
    checks++; if (dut_rec() !== e[0] || ifc.rec_valid !== 1'b1) $display("FAIL basic_first_visible: got %h want %h", dut_rec(), e[0]); else passes++;
    set_retire(3, 16'h0002, 4'd9, 16'hFFFF, 16'hFFFF); tick();
    set_retire(4, 16'h0004, 4'd7, 16'h1111, 16'h2222); tick();
    checks++; if (done !== 1'b1 || inst_count !== 32'd3) $display("FAIL basic_done: got done=%b inst=%0d want 1/3", done, inst_count); else passes++;
    ifc.rec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dut_rec() !== e[i]) $display("FAIL basic_rec%0d: got %h want %h", i, dut_rec(), e[i]); else passes++;
      tick();
    end
    checks++; if (ifc.rec_valid !== 1'b0) $display("FAIL basic_drained: got %b want 0", ifc.rec_valid); else passes++;
  endtask

  task automatic test_load_store();
    mrec_t ld, st;
    ld = {3'd1, 32'd0, 16'h0010, 4'd5, 16'hBEEF, 16'h0040};
    st = {3'd2, 32'd1, 16'h0012, 4'd0, 16'h0042, 16'h00AA};
    do_reset();
    en = 1'b1; tick();
    set_retire(1, 16'h0010, 4'd5, 16'hBEEF, 16'h0040); tick();
    set_retire(2, 16'h0012, 4'd6, 16'h0042, 16'h00AA); tick();
    en = 1'b0;
    checks++; if (dut_rec() !== ld) $display("FAIL load_rec: got %h want %h", dut_rec(), ld); else passes++;
    ifc.rec_ready = 1'b1; tick();
    checks++; if (dut_rec() !== st) $display("FAIL store_rec: got %h want %h", dut_rec(), st); else passes++;
    tick();
    checks++; if (ifc.rec_valid !== 1'b0 || inst_count !== 32'd2) $display("FAIL ls_idle: got valid=%b inst=%0d want 0/2", ifc.rec_valid, inst_count); else passes++;
  endtask

  task automatic test_overflow();
    int n;
    logic [31:0] last;
    do_reset();
    en = 1'b1; tick();
    for (int i = 0; i < DEPTH_A + 2; i++) begin
      set_retire(0, 16'(2 * i), 4'(i), 16'($urandom), 16'($urandom));
      tick();
    end
    en = 1'b0;
    checks++; if (overflow !== 1'b1 || inst_count !== 32'(DEPTH_A + 2)) $display("FAIL ovf_flag: got ovf=%b inst=%0d want 1/%0d", overflow, inst_count, DEPTH_A + 2); else passes++;
    ifc.rec_ready = 1'b1;
    n = 0; last = '1;
    for (int c = 0; c < 20 && ifc.rec_valid; c++) begin
      last = ifc.rec_inum; n++; tick();
    end
    checks++; if (n != DEPTH_A || last !== 32'(DEPTH_A - 1)) $display("FAIL ovf_drain: got n=%0d last=%0d want %0d/%0d", n, last, DEPTH_A, DEPTH_A - 1); else passes++;
  endtask

  task automatic test_halt_pend();
    int n;
    mrec_t last;
    do_reset();
    en = 1'b1; tick();
    for (int i = 0; i < DEPTH_A; i++) begin
      set_retire(0, 16'(i), 4'd1, 16'(i), 16'h0); tick();
    end
    set_retire(4, 16'h0100, 4'd0, 16'h0, 16'h0); tick();
    set_retire(3, 16'h0102, 4'd0, 16'h0, 16'h0); tick(); tick();
    checks++; if (done !== 1'b0 || cycle_count !== 32'(DEPTH_A + 3)) $display("FAIL hp_pending: got done=%b cyc=%0d want 0/%0d", done, cycle_count, DEPTH_A + 3); else passes++;
    ifc.rec_ready = 1'b1; tick(); ifc.rec_ready = 1'b0;
    checks++; if (done !== 1'b1 || inst_count !== 32'(DEPTH_A + 1)) $display("FAIL hp_done: got done=%b inst=%0d want 1/%0d", done, inst_count, DEPTH_A + 1); else passes++;
    ifc.rec_ready = 1'b1;
    n = 0; last = '0;
    for (int c = 0; c < 20 && ifc.rec_valid; c++) begin
      last = dut_rec(); n++; tick();
    end
    checks++; if (n != DEPTH_A || last !== {3'd4, 32'(DEPTH_A), 16'h0100, 4'd0, 16'h0, 16'h0}) $display("FAIL hp_record: got n=%0d last=%h want %0d halt inum %0d", n, last, DEPTH_A, DEPTH_A); else passes++;
    checks++; if (cycle_count !== 32'(DEPTH_A + 4)) $display("FAIL hp_frozen: got cyc=%0d want %0d", cycle_count, DEPTH_A + 4); else passes++;
  endtask

  task automatic test_timeout();
    int n;
    int bad;
    do_reset();
    tif.reg_write = 1'b1; tif.mem_read = 1'b0; tif.mem_write = 1'b0; tif.halt = 1'b0;
    tif.write_reg = 4'd4; tif.mem_addr = 16'h0; tif.mem_data = 16'h0;
    en_t = 1'b1; tick();
    for (int i = 0; i < LIMIT_T + 3; i++) begin
      tif.pc = 16'(i); tif.write_data = 16'(i + 16'h100);
      tick();
      if (i == LIMIT_T - 2) begin
        checks++; if (timeout_t !== 1'b0) $display("FAIL to_early: got %b want 0", timeout_t); else passes++;
      end
      if (i == LIMIT_T - 1) begin
        checks++; if ({timeout_t, done_t} !== 2'b11 || inst_count_t !== 32'(LIMIT_T)) $display("FAIL to_hit: got to=%b done=%b inst=%0d want 1/1/%0d", timeout_t, done_t, inst_count_t, LIMIT_T); else passes++;
      end
    end
    checks++; if (inst_count_t !== 32'(LIMIT_T) || cycle_count_t !== 32'(LIMIT_T)) $display("FAIL to_frozen: got %0d/%0d want %0d/%0d", inst_count_t, cycle_count_t, LIMIT_T, LIMIT_T); else passes++;
    tif.rec_ready = 1'b1;
    n = 0; bad = 0;
    for (int c = 0; c < 40 && tif.rec_valid; c++) begin
      if (tif.rec_inum !== 32'(n) || tif.rec_pc !== 16'(n)) bad++;
      n++; tick();
    end
    checks++; if (n != LIMIT_T || bad != 0) $display("FAIL to_records: got n=%0d bad=%0d want %0d/0", n, bad, LIMIT_T); else passes++;
    en_t = 1'b0; tif.rec_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      set_retire(0, 16'(i), 4'd2, 16'(i), 16'h0); tick();
    end
    rst_n = 1'b0; tick();
    checks++; if (ifc.rec_valid !== 1'b0 || inst_count !== 32'd0 || cycle_count !== 32'd0) $display("FAIL rm_cleared: got valid=%b %0d/%0d want 0/0/0", ifc.rec_valid, inst_count, cycle_count); else passes++;
    rst_n = 1'b1; tick();
    checks++; if (ifc.rec_valid !== 1'b0) $display("FAIL rm_idle: got %b want 0", ifc.rec_valid); else passes++;
    tick();
    checks++; if (ifc.rec_valid !== 1'b1 || ifc.rec_inum !== 32'd0) $display("FAIL rm_restart: got valid=%b inum=%0d want 1/0", ifc.rec_valid, ifc.rec_inum); else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n = !((m_mode >= 3 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 15) != 0);
      ifc.rec_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ifc.reg_write = 1'($urandom); ifc.mem_read = 1'($urandom); ifc.mem_write = 1'($urandom);
      ifc.halt = ($urandom_range(0, 19) == 0);
      ifc.pc = 16'($urandom); ifc.write_reg = 4'($urandom); ifc.write_data = 16'($urandom);
      ifc.mem_addr = 16'($urandom); ifc.mem_data = 16'($urandom);
      tick();
      checks++; if (ifc.rec_valid !== (mq.size() > 0)) $display("FAIL rnd_valid c=%0d: got %b want %b", c, ifc.rec_valid, mq.size() > 0); else passes++;
      checks++; if (dut_rec() !== exp_rec()) $display("FAIL rnd_rec c=%0d: got %h want %h", c, dut_rec(), exp_rec()); else passes++;
      checks++; if (inst_count !== m_ic || cycle_count !== m_cc) $display("FAIL rnd_counters c=%0d: got %0d/%0d want %0d/%0d", c, inst_count, cycle_count, m_ic, m_cc); else passes++;
      checks++; if ({overflow, done, timeout} !== {m_ovf, m_mode >= 3, m_mode == 4}) $display("FAIL rnd_flags c=%0d: got %b want %b", c, {overflow, done, timeout}, {m_ovf, m_mode >= 3, m_mode == 4}); else passes++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    ifc.rec_ready = 1'b0; tif.rec_ready = 1'b0;
    set_retire(3, 16'h0, 4'h0, 16'h0, 16'h0);
    tif.pc = 16'h0; tif.reg_write = 1'b0; tif.write_reg = 4'h0; tif.write_data = 16'h0;
    tif.mem_read = 1'b0; tif.mem_write = 1'b0; tif.mem_addr = 16'h0; tif.mem_data = 16'h0; tif.halt = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_load_store();
    test_overflow();
    test_halt_pend();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
